// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute sequencer:
//   - ALU opcode and shift-mode encodings (match the 2-bit instruction fields)
//   - FSM state encoding
//   - Status bit positions within the 3-bit {Z, N, V} status word
//   - Packed layout of the latched instruction
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MVN = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Bit positions inside status = {Z, N, V}
    localparam int ST_Z = 2;
    localparam int ST_N = 1;
    localparam int ST_V = 0;

    // Instruction fields captured when start is accepted
    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] shift;
        logic [2:0] rn;
        logic [2:0] rm;
        logic [2:0] rd;
        logic       wb_en;
    } instr_t;

endpackage

// File: rtl/alu16.sv
// -----------------------------------------------------------------------------
// alu16
// Combinational shifter + ALU. B is first shifted to B', then combined with A.
// Ports:
//   a, b    - W-bit operands
//   shift   - 00 none, 01 LSL1, 10 LSR1, 11 ASR1 (applied to b)
//   alu_op  - 00 ADD, 01 SUB (a - b'), 10 AND, 11 MVN (~b')
//   result  - W-bit result (modulo 2^W)
//   status  - {Z, N, V}; V only meaningful for ADD/SUB, zero otherwise
// -----------------------------------------------------------------------------
module alu16
    import exec_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   shift,
    input  logic [1:0]   alu_op,
    output logic [W-1:0] result,
    output logic [2:0]   status
);

    logic [W-1:0] b_sh;
    logic         ovf;

    always_comb begin
        case (shift)
            SH_LSL:  b_sh = {b[W-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b[W-1:1]};
            SH_ASR:  b_sh = {b[W-1], b[W-1:1]};
            default: b_sh = b;
        endcase
    end

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                result = a + b_sh;
                // Same-sign operands producing a different-sign sum
                ovf = (a[W-1] == b_sh[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = a - b_sh;
                // Different-sign operands where the sign of A is not preserved
                ovf = (a[W-1] != b_sh[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_AND: result = a & b_sh;
            default: result = ~b_sh;
        endcase
    end

    always_comb begin
        status       = '0;
        status[ST_Z] = (result == '0);
        status[ST_N] = result[W-1];
        status[ST_V] = ovf;
    end

endmodule

// File: rtl/vDFF.sv
// -----------------------------------------------------------------------------
// vDFF
// Generic N-bit D flip-flop bank with asynchronous active-high reset to zero.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (q -> 0)
//   d     - next-state input
//   q     - registered output
// -----------------------------------------------------------------------------
module vDFF #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// -----------------------------------------------------------------------------
// exec_stage
// Multi-cycle execute sequencer driving an 8xW register file.
// Sequence: IDLE -> LOAD_A (A <- Rn) -> LOAD_B (B <- Rm) -> EXEC (C, status)
//           -> WB (done; optional Rd <- C) -> IDLE.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   start             - request, sampled only in IDLE
//   alu_op, shift     - operation and B shift mode (captured on accept)
//   rn, rm, rd, wb_en - sources, destination, write-back enable (captured)
//   rf_data_out       - register file combinational read data
//   rf_readnum        - register file read select
//   rf_writenum       - register file write select
//   rf_write          - register file write enable
//   rf_data_in        - register file write data (always C)
//   busy, done        - not-IDLE flag, one-cycle completion pulse in WB
//   result, status    - C and {Z, N, V}
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module exec_stage
    import exec_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   alu_op,
    input  logic [1:0]   shift,
    input  logic [2:0]   rn,
    input  logic [2:0]   rm,
    input  logic [2:0]   rd,
    input  logic         wb_en,
    input  logic [W-1:0] rf_data_out,
    output logic [2:0]   rf_readnum,
    output logic [2:0]   rf_writenum,
    output logic         rf_write,
    output logic [W-1:0] rf_data_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [2:0]   status
);

    logic [2:0]   state_q, state_d;
    instr_t       instr_q, instr_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [2:0]   status_q, status_d;
    logic [W-1:0] alu_result;
    logic [2:0]   alu_status;
    logic         accept;

    assign accept = (state_q == S_IDLE) && start;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = start ? S_LOAD_A : S_IDLE;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- register next values ----------------
    always_comb begin
        instr_d  = instr_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        if (accept) begin
            instr_d.alu_op = alu_op;
            instr_d.shift  = shift;
            instr_d.rn     = rn;
            instr_d.rm     = rm;
            instr_d.rd     = rd;
            instr_d.wb_en  = wb_en;
        end
        if (state_q == S_LOAD_A) a_d = rf_data_out;
        if (state_q == S_LOAD_B) b_d = rf_data_out;
        if (state_q == S_EXEC) begin
            c_d      = alu_result;
            status_d = alu_status;
        end
    end

    // ---------------- state and datapath registers ----------------
    vDFF #(.N(3))               u_state  (.clk(clk), .reset(reset), .d(state_d),  .q(state_q));
    vDFF #(.N($bits(instr_t)))  u_instr  (.clk(clk), .reset(reset), .d(instr_d),  .q(instr_q));
    vDFF #(.N(W))               u_a      (.clk(clk), .reset(reset), .d(a_d),      .q(a_q));
    vDFF #(.N(W))               u_b      (.clk(clk), .reset(reset), .d(b_d),      .q(b_q));
    vDFF #(.N(W))               u_c      (.clk(clk), .reset(reset), .d(c_d),      .q(c_q));
    vDFF #(.N(3))               u_status (.clk(clk), .reset(reset), .d(status_d), .q(status_q));

    alu16 #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .shift  (instr_q.shift),
        .alu_op (instr_q.alu_op),
        .result (alu_result),
        .status (alu_status)
    );

    // ---------------- Moore outputs ----------------
    always_comb begin
        rf_readnum = 3'd0;
        case (state_q)
            S_LOAD_A: rf_readnum = instr_q.rn;
            S_LOAD_B: rf_readnum = instr_q.rm;
            default:  rf_readnum = 3'd0;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_WB);
    assign rf_write    = done && instr_q.wb_en;
    assign rf_writenum = rf_write ? instr_q.rd : 3'd0;
    assign rf_data_in  = c_q;
    assign result      = c_q;
    assign status      = status_q;

endmodule

// File: tb/tb_exec_stage.sv
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  alu_op, shift;
    logic [2:0]  rn, rm, rd;
    logic        wb_en;
    logic [15:0] rf_data_out;
    logic [2:0]  rf_readnum, rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic        busy, done;
    logic [15:0] result;
    logic [2:0]  status;

    // Register file attached to the block; bench preloads through tb_wr
    logic [15:0] rf [8];
    logic        tb_wr;
    logic [2:0]  tb_wnum;
    logic [15:0] tb_wdata;

    // Reference register file contents
    int rf_model [8];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exec_stage #(.W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .alu_op(alu_op), .shift(shift), .rn(rn), .rm(rm), .rd(rd), .wb_en(wb_en),
        .rf_data_out(rf_data_out), .rf_readnum(rf_readnum), .rf_writenum(rf_writenum),
        .rf_write(rf_write), .rf_data_in(rf_data_in), .busy(busy), .done(done),
        .result(result), .status(status)
    );

    assign rf_data_out = rf[rf_readnum];

    always @(posedge clk) begin
        if (rf_write) rf[rf_writenum] <= rf_data_in;
        else if (tb_wr) rf[tb_wnum] <= tb_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: integer arithmetic straight from the operation rules
    task automatic ref_model(input int op, input int sh, input int a, input int b,
                             output int c, output int st);
        int bp, sa, sb, wide, v;
        case (sh)
            1:       bp = (b * 2) % 65536;
            2:       bp = b / 2;
            3:       bp = b / 2 + ((b >= 32768) ? 32768 : 0);
            default: bp = b;
        endcase
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (bp >= 32768) ? bp - 65536 : bp;
        v  = 0;
        case (op)
            0: begin c = (a + bp) % 65536;         wide = sa + sb; v = (wide > 32767 || wide < -32768) ? 1 : 0; end
            1: begin c = (a - bp + 65536) % 65536; wide = sa - sb; v = (wide > 32767 || wide < -32768) ? 1 : 0; end
            2: c = a & bp;
            default: c = 65535 - bp;
        endcase
        st = ((c == 0) ? 4 : 0) + ((c >= 32768) ? 2 : 0) + v;
    endtask

    task automatic preload(input int idx, input int val);
        @(negedge clk);
        tb_wr = 1'b1; tb_wnum = idx[2:0]; tb_wdata = val[15:0];
        @(posedge clk); #1;
        tb_wr = 1'b0;
        rf_model[idx] = val;
    endtask

    task automatic run_instr(input int op, input int sh, input int n, input int m, input int d,
                             input int wb, input bit pulse, input string tag);
        int exp_c, exp_st, done_cnt;
        ref_model(op, sh, rf_model[n], rf_model[m], exp_c, exp_st);
        @(negedge clk);
        alu_op = op[1:0]; shift = sh[1:0]; rn = n[2:0]; rm = m[2:0]; rd = d[2:0];
        wb_en = wb[0]; start = 1'b1;
        @(posedge clk); #1;
        // Scramble fields: the latched instruction must be used
        start = 1'b0;
        alu_op = 2'($urandom); shift = 2'($urandom);
        rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom); wb_en = 1'($urandom);
        done_cnt = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            check_eq({tag, "_busy"}, busy, 1);
            check_eq({tag, "_done"}, done, (cyc == 4) ? 1 : 0);
            check_eq({tag, "_wr"}, rf_write, (cyc == 4 && wb != 0) ? 1 : 0);
            if (cyc == 4) begin
                check_eq({tag, "_wdata"}, rf_data_in, exp_c);
                if (wb != 0) check_eq({tag, "_wnum"}, rf_writenum, d);
            end
            done_cnt += int'(done);
            start = (pulse && cyc <= 3) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        for (int cyc = 5; cyc <= (pulse ? 8 : 5); cyc++) begin
            @(negedge clk);
            check_eq({tag, "_idle"}, busy, 0);
            done_cnt += int'(done);
        end
        check_eq({tag, "_ndone"}, done_cnt, 1);
        check_eq({tag, "_result"}, result, exp_c);
        check_eq({tag, "_status"}, status, exp_st);
        if (wb != 0) rf_model[d] = exp_c;
        check_eq({tag, "_rd"}, rf[d], rf_model[d]);
        $display("instr %s op=%0d sh=%0d rn=%0d rm=%0d rd=%0d wb=%0d -> result=%h status=%b",
                 tag, op, sh, n, m, d, wb, result, status);
    endtask

    initial begin
        int vals [5];
        reset = 1'b1; start = 1'b0; alu_op = '0; shift = '0;
        rn = '0; rm = '0; rd = '0; wb_en = 1'b0;
        tb_wr = 1'b0; tb_wnum = '0; tb_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wr", rf_write, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_status", status, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) preload(i, int'($urandom_range(0, 65535)));

        // Directed cases
        preload(1, 16'h0007); preload(2, 16'h0003);
        run_instr(0, 0, 1, 2, 3, 1, 1'b0, "add");
        check_eq("add_r3", rf[3], 16'h000A);
        check_eq("add_st", status, 3'b000);

        preload(4, 16'h8000); preload(5, 16'h0001);
        run_instr(1, 0, 4, 5, 6, 1, 1'b0, "sub_ovf");
        check_eq("sub_r6", rf[6], 16'h7FFF);
        check_eq("sub_st", status, 3'b001);

        preload(0, 16'h8004);
        run_instr(3, 3, 1, 0, 7, 1, 1'b0, "mvn_asr");
        check_eq("mvn_asr_r7", rf[7], 16'h3FFD);
        run_instr(3, 2, 1, 0, 7, 1, 1'b0, "mvn_lsr");
        check_eq("mvn_lsr_r7", rf[7], 16'hBFFD);
        check_eq("mvn_lsr_n", status[1], 1);

        preload(2, 16'h00F0);
        run_instr(2, 1, 2, 2, 2, 0, 1'b0, "and_nowb");
        check_eq("and_result", result, 16'h00E0);
        check_eq("and_r2", rf[2], 16'h00F0);

        preload(1, 16'h0005);
        run_instr(0, 0, 1, 1, 1, 1, 1'b0, "self");
        check_eq("self_r1", rf[1], 16'h000A);
        preload(1, 16'h0000);
        run_instr(0, 0, 1, 1, 1, 1, 1'b0, "self_zero");
        check_eq("self_zero_st", status, 3'b100);

        run_instr(0, 1, 3, 6, 5, 1, 1'b1, "pulse");

        // Reset during LOAD_B aborts the instruction
        preload(6, 16'h1234);
        @(negedge clk);
        alu_op = 2'b00; shift = 2'b00; rn = 3'd1; rm = 3'd2; rd = 3'd6; wb_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_wr", rf_write, 0);
        check_eq("mid_rst_result", result, 0);
        check_eq("mid_rst_status", status, 0);
        check_eq("mid_rst_rnum", rf_readnum, 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_busy", busy, 0);
            check_eq("post_rst_wr", rf_write, 0);
        end
        check_eq("post_rst_r6", rf[6], 16'h1234);
        $display("reset during LOAD_B: busy=%b result=%h r6=%h", busy, result, rf[6]);

        // Randomized instructions, biased toward sign/overflow boundaries
        vals[0] = 0; vals[1] = 16'h7FFF; vals[2] = 16'h8000; vals[3] = 16'hFFFF; vals[4] = 1;
        for (int t = 0; t < 30; t++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) preload(r, vals[$urandom_range(0, 4)]);
            else preload(r, int'($urandom_range(0, 65535)));
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Multi-cycle execute sequencer that sits directly downstream of the 8×16-bit register file and also drives its read/write ports. On `start` it reads Rn into operand register A and Rm into operand register B, computes an ALU result from A and shifted B into register C, and updates a 3-bit status register. If the instruction requests write-back, it writes C back to Rd. It is the datapath engine the instruction controller issues register-to-register operations to.

## Interface
Parameters:
- `W`, default 16: datapath width; must match the register file width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `alu_op` in 2: 00 ADD, 01 SUB (A−B'), 10 AND, 11 MVN (~B').
- `shift` in 2: applied to B to give B'. 00 none, 01 LSL1 (zero-fill), 10 LSR1 (zero-fill), 11 ASR1 (sign-fill).
- `rn`, `rm`, `rd` in 3 each: source A, source B, destination.
- `wb_en` in 1: write C to Rd.
- `rf_data_out` in W: register file combinational read data.
- `rf_readnum` out 3: register file read select.
- `rf_writenum` out 3: register file write select.
- `rf_write` out 1: register file write enable.
- `rf_data_in` out W: register file write data, always equal to C.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: high for exactly one cycle, in WB.
- `result` out W: contents of C.
- `status` out 3: {Z, N, V}.

## Operation
- FSM states: IDLE → LOAD_A → LOAD_B → EXEC → WB → IDLE. All transitions are unconditional except IDLE, which leaves only when `start` = 1.
- Instruction capture: on the edge that accepts `start`, latch `alu_op`, `shift`, `rn`, `rm`, `rd`, `wb_en` into internal instruction registers. Input changes after that edge have no effect.
- LOAD_A: `rf_readnum` = latched rn; A ← `rf_data_out` at the end of the cycle.
- LOAD_B: `rf_readnum` = latched rm; B ← `rf_data_out` at the end of the cycle.
- EXEC: C ← alu(A, B'); status ← {Z, N, V} at the end of the cycle.
  - Z = (C == 0).
  - N = C[W−1].
  - V = signed overflow for ADD/SUB; V = 0 for AND/MVN.
  - All arithmetic is W-bit modulo; carry is discarded.
- WB: `done` = 1. If wb_en, `rf_write` = 1 and `rf_writenum` = latched rd, so Rd ← C at the end of WB.
- `rf_readnum` = 0 in IDLE, EXEC and WB. `rf_writenum` = 0 and `rf_write` = 0 outside a WB write.
- `start` while busy is ignored. It is not queued.
- rn = rm = rd is legal. The read values are those before the write-back.
- `result` and `status` hold their values until the next EXEC.

## Timing
- Reset (asynchronous, any state): state → IDLE. A, B, C, status and instruction registers → 0. Consequently `busy` = 0, `done` = 0, `rf_write` = 0, `result` = 0, `status` = 000.
- Reset asserted mid-operation aborts the instruction. No register file write occurs.
- Latency: `start` is sampled at edge 0 → LOAD_A in cycle 1, LOAD_B in cycle 2, EXEC in cycle 3, WB in cycle 4 (`done` high, Rd written at the end of cycle 4). The next `start` can be accepted at the end of cycle 5, i.e. a throughput of 5 cycles per instruction.
- Outputs are Moore outputs decoded from state and registers. There is no combinational path from `start` to any output.

## Structure
- Shared package `exec_pkg` holds:
  - ALU opcode constants: ADD, SUB, AND, MVN.
  - Shift constants: NONE, LSL, LSR, ASR.
  - FSM state encoding.
  - Status bit indices.
- Sub-module `alu16`: combinational shifter plus ALU. Takes A, B, shift and alu_op; produces the result and {Z, N, V}.
- The FSM, A/B/C/status registers and instruction registers are instantiated in `exec_stage` using the existing `vDFF` flop.

## Test plan
The bench preloads the register file through its write port while the block is in IDLE.
- R1 = 0x0007, R2 = 0x0003; ADD rn=1 rm=2 rd=3 shift=00 wb_en=1 → `done` in cycle 4, R3 = 0x000A, status = 000.
- R4 = 0x8000, R5 = 0x0001; SUB rn=4 rm=5 rd=6 → R6 = 0x7FFF, status = 001 (V).
- R0 = 0x8004; MVN rm=0 shift=11 rd=7 → B' = 0xC002, R7 = 0x3FFD, N = 0. Repeat with shift=10 → B' = 0x4002, R7 = 0xBFFD, N = 1.
- R2 = 0x00F0; AND rn=2 rm=2 shift=01 wb_en=0 → `result` = 0x00E0, `rf_write` never asserted, R2 unchanged.
- Self-update: R1 = 0x0005; ADD rn=rm=rd=1 → R1 = 0x000A. Repeat with 0x0000 → status Z = 1.
- Pulse `start` in cycles 1–3 → ignored, exactly one `done`. Separately, assert `reset` during LOAD_B → IDLE immediately, all outputs zero, Rd unchanged.
